vector_reduce_acc: RTL and testbench
====================================

# vector_reduce_acc

Pipelined, parametrised vector reduction with multi-beat accumulation. Each valid beat carries `VECTOR_LENGTH` elements. A registered binary adder tree sums them. A running accumulator then sums tree results over a packet delimited by `in_first`/`in_last`, and emits one total per packet with an overflow flag and a beat count. It sits downstream of the dot-product and MAC datapaths. It reduces wide partial-product vectors that arrive over several cycles, and supports both signed and unsigned operands.

## Interface
- `VECTOR_LENGTH`, 7: elements per beat; any value ≥1. The tree pads to the next power of two with zeros.
- `DATA_WIDTH`, 16: width of each element.
- `SIGNED`, 0: 1 means elements are two's complement and are sign-extended at every stage; 0 means zero-extended.
- `ACC_WIDTH`, `DATA_WIDTH+TREE_STAGES+8`: accumulator and output width; must be ≥ `DATA_WIDTH+TREE_STAGES`.
- `COUNT_WIDTH`, 8: width of the beat counter.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: the beat is present this cycle.
- `in_first` in 1: the beat starts a new packet (qualified by `in_valid`).
- `in_last` in 1: the beat ends its packet (qualified by `in_valid`).
- `vector_in` in `VECTOR_LENGTH*DATA_WIDTH`: element k occupies bits `[(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]`.
- `out_valid` out 1: single-cycle pulse when a packet total is presented.
- `out_sum` out `ACC_WIDTH`: the packet total.
- `out_overflow` out 1: sticky over the packet; set if any accumulate step overflowed.
- `out_beats` out `COUNT_WIDTH`: number of beats in the packet, saturating at all-ones.

## Operation
- `TREE_STAGES = max(1, clog2(VECTOR_LENGTH))`. Stage s produces `DATA_WIDTH+s+1`-bit partial sums.
- The tree is exact: no overflow is possible at any tree stage.
- `in_valid`, `in_first` and `in_last` travel down a shift register alongside the tree, so each control bit stays aligned with its beat.
- Accumulate stage, applied when the tree-output valid is high:
  - The tree sum is extended to `ACC_WIDTH`.
  - If first: `acc = ext`, `ovf = 0`, `cnt = 1`.
  - Otherwise: `acc = acc + ext` modulo 2^`ACC_WIDTH`, `ovf |= step_overflow`, `cnt = sat(cnt+1)`.
- `step_overflow` depends on `SIGNED`:
  - Unsigned: carry out of the accumulator MSB.
  - Signed: operand signs are equal and the result sign differs from them.
- If last, the post-update `acc`, `ovf` and `cnt` are registered to the outputs and `out_valid` pulses.
- A beat with first and last both set is a one-beat packet.
- A beat with neither flag set continues the current packet. So does a beat without first after reset; the accumulator starts from 0 after reset.
- A first beat arriving mid-packet abandons the old packet silently: no output and no error.
- There is no backpressure. The downstream consumer must accept every `out_valid` pulse. Beats may arrive on every cycle.
- Reset clears all pipeline valids, `acc`, `ovf`, `cnt` and all outputs (`out_valid=0`, `out_sum=0`, `out_overflow=0`, `out_beats=0`). Beats in flight when reset is asserted are discarded.

## Timing
- Latency from `in_valid && in_last` at cycle t to `out_valid` at cycle t+`TREE_STAGES`+1.
  - Defaults (`TREE_STAGES=3`): 4 cycles.
- Throughput is one beat per cycle. Back-to-back one-beat packets produce `out_valid` on consecutive cycles.
- `out_sum`, `out_overflow` and `out_beats` hold their values between pulses. They change only when `out_valid` is high.
- `in_*` are sampled only when `in_valid` is high. Flags on invalid cycles are ignored.
- Reset asserted at cycle t: `out_valid` is 0 from t+1, including for beats accepted before t.

## Structure
- Shared package `vector_reduce_pkg`:
  - a `clog2` helper function;
  - a `TREE_STAGES` computation function;
  - an `extend(value, width, signed)` function reused by the tree and the accumulator.
- Sub-module `adder_tree_stage`: one registered level of pairwise adds.
  - Parameters: input count, input width, `SIGNED`.
  - Instantiated `TREE_STAGES` times in a generate loop, with a zero-padded odd tail.
- The top level holds the control shift register, the accumulator and the output registers.

## Test plan
- Defaults, one-beat packet with elements 1..7 → after 4 cycles, `out_valid=1`, `out_sum=28`, `out_beats=1`, `out_overflow=0`.
- Three-beat packet with all elements 0xFFFF and `SIGNED=0` → `out_sum=3*7*65535=1376235`, `out_beats=3`, one pulse only.
- `SIGNED=1`, elements all -1 (0xFFFF), one-beat packet → `out_sum=-7` sign-extended to `ACC_WIDTH`.
- `ACC_WIDTH=20`, unsigned, two beats each summing 0x7FFF9 → `out_sum=0xFFFF2`, `out_overflow=0`. A third beat of the same value → `out_overflow=1` and `out_sum` wrapped.
- Back-to-back one-beat packets on 10 consecutive cycles with distinct data → 10 consecutive `out_valid` pulses in order with correct sums.
- Reset pulsed two cycles after a last beat → no `out_valid`, all outputs 0. A next packet of 1..7 yields 28.

Source files
------------

// File: rtl/vector_reduce_pkg.sv
// Shared helpers for the vector reduction accumulator.
//   clog2        : ceiling log2, used to size the adder tree
//   tree_stages  : number of registered tree levels (at least one)
//   extend       : widens the low 'width' bits of a value to EXT_MAX_W bits,
//                  sign- or zero-filled; callers cast the result to the width
//                  they need.
package vector_reduce_pkg;

  localparam int EXT_MAX_W = 128;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int tree_stages(input int vector_length);
    return (clog2(vector_length) < 1) ? 1 : clog2(vector_length);
  endfunction

  function automatic logic [EXT_MAX_W-1:0] extend(
    input logic [EXT_MAX_W-1:0] value,
    input int                   width,
    input logic                 is_signed
  );
    logic [EXT_MAX_W-1:0] mask;
    logic                 fill;
    mask = (width >= EXT_MAX_W) ? '1 : ((EXT_MAX_W'(1) << width) - EXT_MAX_W'(1));
    fill = is_signed & (|(value & (EXT_MAX_W'(1) << (width - 1))));
    return (value & mask) | (fill ? ~mask : '0);
  endfunction

endpackage

// File: rtl/vector_reduce_acc_if.sv
// Beat input / packet-total output bundle of vector_reduce_acc.
//   in_valid, in_first, in_last, vector_in : beat from the upstream datapath
//   out_valid, out_sum, out_overflow, out_beats : one packet total per pulse
// Handshake: valid-only, no ready. A beat is taken on every rising clk edge
// where in_valid is high; in_first/in_last/vector_in are ignored otherwise.
// out_valid is a one-cycle pulse the consumer must take; out_sum,
// out_overflow and out_beats hold their values between pulses.
interface vector_reduce_acc_if import vector_reduce_pkg::*; #(
  parameter int VECTOR_LENGTH = 7,
  parameter int DATA_WIDTH    = 16,
  parameter int ACC_WIDTH     = DATA_WIDTH + tree_stages(VECTOR_LENGTH) + 8,
  parameter int COUNT_WIDTH   = 8
);
  logic                                in_valid;
  logic                                in_first;
  logic                                in_last;
  logic [VECTOR_LENGTH*DATA_WIDTH-1:0] vector_in;
  logic                                out_valid;
  logic [ACC_WIDTH-1:0]                out_sum;
  logic                                out_overflow;
  logic [COUNT_WIDTH-1:0]              out_beats;

  modport master (
    output in_valid, in_first, in_last, vector_in,
    input  out_valid, out_sum, out_overflow, out_beats
  );

  modport slave (
    input  in_valid, in_first, in_last, vector_in,
    output out_valid, out_sum, out_overflow, out_beats
  );
endinterface

// File: rtl/vector_reduce_acc_adder_tree_stage.sv
// One registered level of the reduction tree: adds neighbouring elements in
// pairs. An odd element count is padded with a zero element, so the tail
// passes through unchanged. Outputs are one bit wider than inputs, so the
// level cannot overflow.
//   clk, rst : clock, synchronous active-high reset
//   in_data  : N_IN elements of IN_W bits, element k at [k*IN_W +: IN_W]
//   out_data : ceil(N_IN/2) elements of IN_W+1 bits, registered
module adder_tree_stage import vector_reduce_pkg::*; #(
  parameter int N_IN   = 2,
  parameter int IN_W   = 16,
  parameter int SIGNED = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_IN*IN_W-1:0]                  in_data,
  output logic [((N_IN+1)/2)*(IN_W+1)-1:0]      out_data
);
  localparam int N_OUT = (N_IN + 1) / 2;
  localparam int OUT_W = IN_W + 1;

  logic [2*N_OUT*IN_W-1:0] padded;
  logic [N_OUT*OUT_W-1:0]  sum_c;

  assign padded = (2*N_OUT*IN_W)'(in_data);

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N_OUT; k++) begin
      sum_c[k*OUT_W +: OUT_W] = OUT_W'(
        extend(EXT_MAX_W'(padded[(2*k)*IN_W +: IN_W]), IN_W, SIGNED != 0) +
        extend(EXT_MAX_W'(padded[(2*k+1)*IN_W +: IN_W]), IN_W, SIGNED != 0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_data <= '0;
    else     out_data <= sum_c;
  end
endmodule

// File: rtl/vector_reduce_acc.sv
// Pipelined vector reduction with per-packet accumulation. Each beat's
// VECTOR_LENGTH elements are summed by a registered adder tree; tree results
// are accumulated between in_first and in_last, and one total per packet is
// presented with a sticky overflow flag and a saturating beat count.
// Latency from the last beat to out_valid is TREE_STAGES+1 cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vector_reduce_acc_if slave (beat in, packet total out)
// ACC_WIDTH must be at least DATA_WIDTH+TREE_STAGES.
module vector_reduce_acc import vector_reduce_pkg::*; #(
  parameter int VECTOR_LENGTH = 7,
  parameter int DATA_WIDTH    = 16,
  parameter int SIGNED        = 0,
  parameter int ACC_WIDTH     = DATA_WIDTH + tree_stages(VECTOR_LENGTH) + 8,
  parameter int COUNT_WIDTH   = 8
) (
  input logic               clk,
  input logic               rst,
  vector_reduce_acc_if.slave bus
);
  localparam int TREE_STAGES = tree_stages(VECTOR_LENGTH);
  localparam int TREE_W      = DATA_WIDTH + TREE_STAGES;

  // Adder tree: level s takes ceil(VECTOR_LENGTH/2^s) elements of
  // DATA_WIDTH+s bits; the last level leaves a single TREE_W-bit sum.
  for (genvar s = 0; s < TREE_STAGES; s++) begin : g_stage
    localparam int N_IN  = (VECTOR_LENGTH + (1 << s) - 1) >> s;
    localparam int N_OUT = (N_IN + 1) / 2;
    localparam int IN_W  = DATA_WIDTH + s;

    logic [N_IN*IN_W-1:0]      stage_in;
    logic [N_OUT*(IN_W+1)-1:0] stage_out;

    if (s == 0) begin : g_src
      assign stage_in = bus.vector_in;
    end else begin : g_src
      assign stage_in = g_stage[s-1].stage_out;
    end

    adder_tree_stage #(
      .N_IN   (N_IN),
      .IN_W   (IN_W),
      .SIGNED (SIGNED)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_data  (stage_in),
      .out_data (stage_out)
    );
  end

  logic [TREE_W-1:0] tree_sum;
  assign tree_sum = g_stage[TREE_STAGES-1].stage_out;

  // Control bits ride alongside the tree. Flags are masked with in_valid on
  // entry so flags on idle cycles can never reach the accumulator.
  logic [TREE_STAGES-1:0] vld_sr, first_sr, last_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr   <= '0;
      first_sr <= '0;
      last_sr  <= '0;
    end else begin
      vld_sr[0]   <= bus.in_valid;
      first_sr[0] <= bus.in_valid & bus.in_first;
      last_sr[0]  <= bus.in_valid & bus.in_last;
      for (int i = 1; i < TREE_STAGES; i++) begin
        vld_sr[i]   <= vld_sr[i-1];
        first_sr[i] <= first_sr[i-1];
        last_sr[i]  <= last_sr[i-1];
      end
    end
  end

  logic tree_vld, tree_first, tree_last;
  assign tree_vld   = vld_sr[TREE_STAGES-1];
  assign tree_first = first_sr[TREE_STAGES-1];
  assign tree_last  = last_sr[TREE_STAGES-1];

  // Accumulate step
  logic [ACC_WIDTH-1:0]   tree_ext, acc_q, acc_nxt;
  logic [ACC_WIDTH:0]     raw_sum;
  logic                   step_ovf, ovf_q, ovf_nxt;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_nxt;

  always_comb begin
    tree_ext = ACC_WIDTH'(extend(EXT_MAX_W'(tree_sum), TREE_W, SIGNED != 0));
    raw_sum  = {1'b0, acc_q} + {1'b0, tree_ext};
    if (SIGNED != 0) begin
      // Two's complement overflow: like-signed operands, differently signed result.
      step_ovf = (acc_q[ACC_WIDTH-1] == tree_ext[ACC_WIDTH-1]) &&
                 (raw_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    end else begin
      step_ovf = raw_sum[ACC_WIDTH];
    end
    if (tree_first) begin
      acc_nxt = tree_ext;
      ovf_nxt = 1'b0;
      cnt_nxt = COUNT_WIDTH'(1);
    end else begin
      acc_nxt = raw_sum[ACC_WIDTH-1:0];
      ovf_nxt = ovf_q | step_ovf;
      cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q            <= '0;
      ovf_q            <= 1'b0;
      cnt_q            <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_sum      <= '0;
      bus.out_overflow <= 1'b0;
      bus.out_beats    <= '0;
    end else begin
      bus.out_valid <= tree_vld & tree_last;
      if (tree_vld) begin
        acc_q <= acc_nxt;
        ovf_q <= ovf_nxt;
        cnt_q <= cnt_nxt;
        if (tree_last) begin
          bus.out_sum      <= acc_nxt;
          bus.out_overflow <= ovf_nxt;
          bus.out_beats    <= cnt_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_vector_reduce_acc.sv
// Bench for vector_reduce_acc. Three instances share clock, reset and beat
// stimulus: a = defaults (unsigned, 16-bit, ACC 27), b = signed (16-bit,
// ACC 27), c = unsigned 17-bit elements with ACC_WIDTH 20. A reference model
// sums the elements directly and queues one expected total per packet,
// tagged with the cycle it must appear on.
module tb_vector_reduce_acc;
  localparam int VL      = 7;
  localparam int N_DUT   = 3;
  localparam int LATENCY = 4;
  localparam int DW_T [N_DUT] = '{16, 16, 17};
  localparam int AW_T [N_DUT] = '{27, 27, 20};
  localparam bit SG_T [N_DUT] = '{1'b0, 1'b1, 1'b0};

  typedef struct {
    int unsigned                cyc;
    logic [N_DUT-1:0][63:0]     sum;
    logic [N_DUT-1:0]           ovf;
    logic [N_DUT-1:0][7:0]      beats;
  } exp_t;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] elem [VL];
  logic [31:0] drv  [VL];
  logic [63:0] m_acc [N_DUT];
  bit          m_ovf [N_DUT];
  int          m_cnt [N_DUT];
  string       dn    [N_DUT] = '{"a", "b", "c"};

  vector_reduce_acc_if #(.VECTOR_LENGTH(7), .DATA_WIDTH(16), .ACC_WIDTH(27), .COUNT_WIDTH(8)) if_a ();
  vector_reduce_acc_if #(.VECTOR_LENGTH(7), .DATA_WIDTH(16), .ACC_WIDTH(27), .COUNT_WIDTH(8)) if_b ();
  vector_reduce_acc_if #(.VECTOR_LENGTH(7), .DATA_WIDTH(17), .ACC_WIDTH(20), .COUNT_WIDTH(8)) if_c ();

  vector_reduce_acc #(.VECTOR_LENGTH(7), .DATA_WIDTH(16), .SIGNED(0), .ACC_WIDTH(27), .COUNT_WIDTH(8))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  vector_reduce_acc #(.VECTOR_LENGTH(7), .DATA_WIDTH(16), .SIGNED(1), .ACC_WIDTH(27), .COUNT_WIDTH(8))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  vector_reduce_acc #(.VECTOR_LENGTH(7), .DATA_WIDTH(17), .SIGNED(0), .ACC_WIDTH(20), .COUNT_WIDTH(8))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic put_inputs(input logic v, input logic f, input logic l);
    if_a.in_valid = v; if_a.in_first = f; if_a.in_last = l;
    if_b.in_valid = v; if_b.in_first = f; if_b.in_last = l;
    if_c.in_valid = v; if_c.in_first = f; if_c.in_last = l;
    for (int k = 0; k < VL; k++) begin
      if_a.vector_in[k*16 +: 16] = drv[k][15:0];
      if_b.vector_in[k*16 +: 16] = drv[k][15:0];
      if_c.vector_in[k*17 +: 17] = drv[k][16:0];
    end
  endtask

  function automatic bit bit_at(input logic [63:0] x, input int i);
    return ((x >> i) & 64'd1) != 64'd0;
  endfunction

  task automatic model_beat(input bit first, input bit last);
    exp_t        e;
    longint      s, v;
    logic [63:0] amask, ext, raw;
    bit          step;
    e.cyc = cyc + LATENCY;
    for (int d = 0; d < N_DUT; d++) begin
      amask = (64'd1 << AW_T[d]) - 64'd1;
      s = 0;
      for (int k = 0; k < VL; k++) begin
        v = longint'(elem[k] & ((32'd1 << DW_T[d]) - 32'd1));
        if (SG_T[d] && bit_at(64'(v), DW_T[d] - 1)) v = v - (longint'(1) << DW_T[d]);
        s = s + v;
      end
      ext = 64'(s) & amask;
      if (first) begin
        m_acc[d] = ext;
        m_ovf[d] = 1'b0;
        m_cnt[d] = 1;
      end else begin
        raw = m_acc[d] + ext;
        if (SG_T[d])
          step = (bit_at(m_acc[d], AW_T[d]-1) == bit_at(ext, AW_T[d]-1)) &&
                 (bit_at(raw, AW_T[d]-1) != bit_at(m_acc[d], AW_T[d]-1));
        else
          step = bit_at(raw, AW_T[d]);
        m_acc[d] = raw & amask;
        m_ovf[d] = m_ovf[d] | step;
        m_cnt[d] = (m_cnt[d] >= 255) ? 255 : m_cnt[d] + 1;
      end
      e.sum[d]   = m_acc[d];
      e.ovf[d]   = m_ovf[d];
      e.beats[d] = 8'(m_cnt[d]);
    end
    if (last) exp_q.push_back(e);
  endtask

  task automatic send(input bit first, input bit last);
    @(posedge clk); #1;
    for (int k = 0; k < VL; k++) drv[k] = elem[k];
    put_inputs(1'b1, first, last);
    model_beat(first, last);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      for (int k = 0; k < VL; k++) drv[k] = $urandom;
      put_inputs(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic check_outputs_zero();
    check("a_rst_valid", 64'(if_a.out_valid), 0);
    check("a_rst_sum",   64'(if_a.out_sum), 0);
    check("a_rst_ovf",   64'(if_a.out_overflow), 0);
    check("a_rst_beats", 64'(if_a.out_beats), 0);
    check("b_rst_valid", 64'(if_b.out_valid), 0);
    check("b_rst_sum",   64'(if_b.out_sum), 0);
    check("b_rst_ovf",   64'(if_b.out_overflow), 0);
    check("b_rst_beats", 64'(if_b.out_beats), 0);
    check("c_rst_valid", 64'(if_c.out_valid), 0);
    check("c_rst_sum",   64'(if_c.out_sum), 0);
    check("c_rst_ovf",   64'(if_c.out_overflow), 0);
    check("c_rst_beats", 64'(if_c.out_beats), 0);
  endtask

  // Reset takes effect on the edge after rst rises; anything still expected
  // from that edge onward is discarded.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    put_inputs(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    exp_q.delete();
    for (int d = 0; d < N_DUT; d++) begin
      m_acc[d] = '0;
      m_ovf[d] = 1'b0;
      m_cnt[d] = 0;
    end
    check_outputs_zero();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // scoreboard monitor
  exp_t        mon_exp;
  logic [2:0]  mon_valid;
  logic [63:0] mon_sum   [N_DUT];
  logic [2:0]  mon_ovf;
  logic [7:0]  mon_beats [N_DUT];

  always @(negedge clk) begin
    mon_valid    = {if_c.out_valid, if_b.out_valid, if_a.out_valid};
    mon_ovf      = {if_c.out_overflow, if_b.out_overflow, if_a.out_overflow};
    mon_sum[0]   = 64'(if_a.out_sum);
    mon_sum[1]   = 64'(if_b.out_sum);
    mon_sum[2]   = 64'(if_c.out_sum);
    mon_beats[0] = if_a.out_beats;
    mon_beats[1] = if_b.out_beats;
    mon_beats[2] = if_c.out_beats;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_exp = exp_q.pop_front();
      for (int d = 0; d < N_DUT; d++) begin
        check($sformatf("%s_out_valid", dn[d]), 64'(mon_valid[d]), 1);
        check($sformatf("%s_out_sum", dn[d]), mon_sum[d], mon_exp.sum[d]);
        check($sformatf("%s_out_overflow", dn[d]), 64'(mon_ovf[d]), 64'(mon_exp.ovf[d]));
        check($sformatf("%s_out_beats", dn[d]), 64'(mon_beats[d]), 64'(mon_exp.beats[d]));
      end
    end else if (!$isunknown(mon_valid) && mon_valid != 3'b000) begin
      check("unexpected_out_valid", 64'(mon_valid), 0);
    end
  end

  initial begin
    for (int k = 0; k < VL; k++) begin
      elem[k] = '0;
      drv[k]  = '0;
    end
    put_inputs(1'b0, 1'b0, 1'b0);
    do_reset();

    // one-beat packet 1..7
    for (int k = 0; k < VL; k++) elem[k] = 32'(k + 1);
    send(1, 1);
    idle(6);

    // three beats of all-ones 16-bit elements, with an idle gap
    for (int k = 0; k < VL; k++) elem[k] = 32'hFFFF;
    send(1, 0);
    idle(1);
    send(0, 0);
    send(0, 1);
    idle(6);

    // per-beat sum 0x7FFF9 on the 17-bit/20-bit instance: 2 beats fit, 3 wrap
    elem = '{32'h1FFFF, 32'h1FFFE, 32'h1FFFE, 32'h1FFFE, 32'h0, 32'h0, 32'h0};
    send(1, 0);
    send(0, 1);
    send(1, 0);
    send(0, 0);
    send(0, 1);
    idle(6);

    // ten back-to-back one-beat packets
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < VL; k++) elem[k] = $urandom;
      send(1, 1);
    end
    idle(6);

    // abandoned packet, then flagless beats continuing the last packet
    for (int k = 0; k < VL; k++) elem[k] = $urandom;
    send(1, 0);
    send(0, 0);
    for (int k = 0; k < VL; k++) elem[k] = $urandom;
    send(1, 0);
    send(0, 1);
    send(0, 0);
    send(0, 1);
    idle(6);

    // after reset, a packet without a first beat starts from zero
    do_reset();
    for (int k = 0; k < VL; k++) elem[k] = $urandom;
    send(0, 0);
    send(0, 1);
    idle(6);

    // reset two cycles after a last beat drops its result
    for (int k = 0; k < VL; k++) elem[k] = 32'(k + 1);
    send(1, 1);
    idle(1);
    do_reset();
    send(1, 1);
    idle(6);

    // long packet: beat count saturates, signed/20-bit accumulators overflow
    for (int k = 0; k < VL; k++) elem[k] = 32'h7FFF;
    send(1, 0);
    repeat (298) send(0, 0);
    send(0, 1);
    idle(6);

    // random packets with random gaps
    for (int p = 0; p < 20; p++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        for (int k = 0; k < VL; k++) elem[k] = $urandom;
        send(b == 0, b == len - 1);
        idle($urandom_range(0, 2));
      end
    end
    idle(8);

    check("queue_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
